// File: rtl/led_pkg.sv
// led_pkg: mode encoding, entry patterns and pattern-step helpers shared by the LED controller
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_FLOW  = 2'd1,
        MODE_BLINK = 2'd2
    } mode_e;

    localparam logic [3:0] PAT_OFF_INIT   = 4'b0000;
    localparam logic [3:0] PAT_FLOW_INIT  = 4'b0001;
    localparam logic [3:0] PAT_BLINK_INIT = 4'b1111;

    function automatic logic [3:0] entry_pat(input mode_e m);
        return m == MODE_FLOW ? PAT_FLOW_INIT : m == MODE_BLINK ? PAT_BLINK_INIT : PAT_OFF_INIT;
    endfunction

    function automatic logic [3:0] next_pat(input mode_e m, input logic [3:0] p);
        return m == MODE_FLOW ? {p[2:0], p[3]} : m == MODE_BLINK ? ~p : p;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes an active-low button, filters glitches and emits a one-cycle press pulse
module key_debounce
    import led_pkg::*;
#(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_stable,
    output logic key_press
);

    localparam int W = $clog2(DEB_CNT);
    localparam logic [W-1:0] LAST = W'(DEB_CNT - 1);

    logic         sync1_q, sync2_q, stable_q, stable_d, prev_q, press_q, differ;
    logic [W-1:0] cnt_q, cnt_d;

    // accept the synchronized level only after it has differed for DEB_CNT cycles
    always_comb begin
        differ   = sync2_q != stable_q;
        cnt_d    = (!differ || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        stable_d = (differ && cnt_q == LAST) ? sync2_q : stable_q;
    end

    // synchronizer, filter state and registered falling-edge detect
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            prev_q   <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            press_q  <= prev_q & ~stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign key_stable = stable_q;
    assign key_press  = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: debounced four-key mode controller driving a timed FLOW/BLINK LED pattern
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int DEB_CNT  = 1_000_000,
    parameter int STEP_CNT = 25_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key1,
    input  logic       key2,
    input  logic       key3,
    input  logic       key4,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic [1:0] mode,
    output logic       paused
);

    localparam int SW = $clog2(STEP_CNT);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CNT - 1);

    logic [3:0]    keys_n, stable, press, evt, pat_q, pat_d;
    logic [SW-1:0] step_q, step_d;
    logic          paused_q, paused_d, run, step_evt, mode_hit;
    mode_e         mode_q, mode_d, sel;

    assign keys_n = {key4, key3, key2, key1};

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .sys_clk   (sys_clk),
            .sys_rst   (sys_rst),
            .key_in    (keys_n[k]),
            .key_stable(stable[k]),
            .key_press (press[k])
        );
    end

    // act on a press only while the debounced level still reads pressed
    assign evt = press & ~stable;

    // state register: mode, pause flag, step timer and pattern
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q   <= MODE_OFF;
            paused_q <= 1'b0;
            step_q   <= '0;
            pat_q    <= PAT_OFF_INIT;
        end else begin
            mode_q   <= mode_d;
            paused_q <= paused_d;
            step_q   <= step_d;
            pat_q    <= pat_d;
        end
    end

    // next state: mode presses (key1 > key2 > key3) override pause toggles and timer steps
    always_comb begin
        run      = mode_q != MODE_OFF && !paused_q;
        step_evt = run && step_q == STEP_LAST;
        mode_hit = |evt[2:0];
        sel      = evt[0] ? MODE_OFF : evt[1] ? MODE_FLOW : MODE_BLINK;
        mode_d   = mode_hit ? sel : mode_q;
        paused_d = mode_hit ? 1'b0 : (evt[3] && mode_q != MODE_OFF) ? ~paused_q : paused_q;
        step_d   = (mode_hit || step_evt) ? '0 : run ? step_q + 1'b1 : step_q;
        pat_d    = mode_hit ? entry_pat(sel) : step_evt ? next_pat(mode_q, pat_q) : pat_q;
    end

    // outputs come straight from registers
    always_comb begin
        {led4, led3, led2, led1} = pat_q;
        mode                     = mode_q;
        paused                   = paused_q;
    end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
- Controller for the four-key / four-LED board datapath.
- Debounces the four raw push-buttons, converts each press into a one-cycle event, and runs a mode state machine (OFF / FLOW / BLINK with pause).
- Drives led1..led4 from a timed pattern generator.
- Sits between the board pins and the LEDs; replaces the direct key-to-LED wiring of the earlier LED block.

Parameters:
- DEB_CNT, 1_000_000, stable-level cycles required to accept a key change (20 ms at 50 MHz).
- STEP_CNT, 25_000_000, cycles per pattern step (0.5 s at 50 MHz).

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- key1  in  1  raw button, active-low (0 = pressed); selects OFF.
- key2  in  1  raw button, active-low; selects FLOW.
- key3  in  1  raw button, active-low; selects BLINK.
- key4  in  1  raw button, active-low; toggles pause.
- led1..led4  out  1 each  LED drive, active-high; led1 = pattern bit 0.
- mode  out  2  current mode: 0 = OFF, 1 = FLOW, 2 = BLINK (3 unused).
- paused  out  1  high while the pattern is frozen.

Behaviour:
- Reset (async, sys_rst = 1), applied immediately, also mid-operation:
  - mode = OFF, paused = 0, LEDs = 0000.
  - Step counter = 0.
  - Synchronizer flops and debounced levels = 1 (released); debounce counters = 0.
- Per-key debounce:
  - 2-FF synchronizer produces `sync`.
  - If `sync` == `stable`: counter clears.
  - If `sync` differs: counter increments. When the counter reaches DEB_CNT-1 while still differing, `stable` takes `sync` and the counter clears.
  - Any return to equality before that point clears the counter, so glitches shorter than DEB_CNT cycles are rejected.
  - `press` = one-cycle pulse on the `stable` 1->0 transition; release generates nothing.
  - Latency: raw falling edge to press pulse = DEB_CNT + 3 cycles.
- Mode select (priority key1 > key2 > key3 when press pulses coincide):
  - Any mode press, including re-pressing the current mode, loads the new mode, clears paused, clears the step counter and loads the entry pattern. The LEDs show the entry pattern on the cycle after the pulse.
  - Entry patterns: OFF = 0000, FLOW = 0001, BLINK = 1111.
- Pause (key4):
  - In FLOW/BLINK, a key4 press toggles paused.
  - In OFF, key4 is ignored and paused stays 0.
  - If key4 coincides with a mode press, the mode press wins and paused = 0.
- Step timer:
  - Counts 0..STEP_CNT-1 only when mode != OFF and paused = 0; otherwise holds its value.
  - Raises a step event on the wrap from STEP_CNT-1 to 0.
  - Resuming continues from the held count, so the first step after resume comes after the remaining cycles, not a full period.
- On each step event:
  - FLOW: rotate left: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - BLINK: invert: 1111 <-> 0000.
  - OFF: never steps.
- Widths: counters are $clog2(param) bits; no other arithmetic.
- All outputs are registered; no combinational path from keys to LEDs.

Decomposition:
- Shared package led_pkg:
  - Mode encoding constants MODE_OFF = 2'd0, MODE_FLOW = 2'd1, MODE_BLINK = 2'd2.
  - Entry pattern constants PAT_FLOW_INIT = 4'b0001, PAT_BLINK_INIT = 4'b1111.
- One sub-module, key_debounce (parameter DEB_CNT; ports sys_clk, sys_rst, key_in, key_stable, key_press), instantiated four times.
- FSM, step timer and pattern register live in the top module.

Test Plan:
(Bench parameters: DEB_CNT = 4, STEP_CNT = 8.)
1. Hold sys_rst = 1 for 3 cycles, keys = 1 -> LEDs = 0000, mode = 0, paused = 0 throughout and after release.
2. key2 low for 3 cycles, then high -> glitch rejected: mode stays 0, LEDs stay 0000, no press pulse.
3. key2 held low, then released -> press pulse DEB_CNT + 3 cycles after the edge. mode = 1, LEDs = 0001, then 0010 8 cycles later, 0100, 1000, 0001 at 8-cycle spacing.
4. In FLOW, press key4 -> paused = 1, LEDs frozen for 40 cycles. Press key4 again -> paused = 0, next step after the remaining count, then steps every 8 cycles.
5. key3 press -> mode = 2, LEDs = 1111, 0000 8 cycles later, 1111 8 cycles after that. key1 and key3 pressed in the same cycle -> mode = 0, LEDs = 0000.
6. Assert sys_rst asynchronously (between clock edges) in FLOW with LEDs = 0100 -> LEDs = 0000, mode = 0, paused = 0 before the next clock edge. After release, key1 press in OFF leaves state unchanged, and key4 press in OFF leaves paused = 0.
